// File: rtl/fp_pkg.sv
// Shared floating-point helpers: operand classes, bias, canonical NaN and field extraction.
// Reused by the multiplier, adder and comparator; widths are passed in as arguments.
package fp_pkg;

  typedef enum logic [1:0] {
    FP_ZERO = 2'd0,
    FP_NORM = 2'd1,
    FP_INF  = 2'd2,
    FP_NAN  = 2'd3
  } fp_class_t;

  localparam int FP_MAX_W = 64;
  typedef logic [FP_MAX_W-1:0] fp_word_t;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic fp_word_t fp_ones(input int n);
    return (fp_word_t'(1) << n) - fp_word_t'(1);
  endfunction

  // Sign 0, exponent all-ones, mantissa MSB set.
  function automatic fp_word_t fp_canon_nan(input int exp_w, input int mant_w);
    return (fp_ones(exp_w) << mant_w) | (fp_word_t'(1) << (mant_w - 1));
  endfunction

  function automatic fp_word_t fp_exp_field(input fp_word_t w, input int exp_w, input int mant_w);
    return (w >> mant_w) & fp_ones(exp_w);
  endfunction

  function automatic fp_word_t fp_mant_field(input fp_word_t w, input int mant_w);
    return w & fp_ones(mant_w);
  endfunction

  function automatic logic fp_sign(input fp_word_t w, input int exp_w, input int mant_w);
    return w[exp_w + mant_w];
  endfunction

  // Zero exponent flushes denormals to zero regardless of mantissa.
  function automatic fp_class_t fp_classify(input fp_word_t e, input fp_word_t m, input int exp_w);
    if (e == '0) return FP_ZERO;
    if (e == fp_ones(exp_w)) return (m == '0) ? FP_INF : FP_NAN;
    return FP_NORM;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result bundle of the pipelined multiplier; master drives operands, slave returns products.
interface fp_mult_pipe_if #(
  parameter int EXP  = 8,
  parameter int MANT = 9
);
  localparam int WIDTH = 1 + EXP + MANT;

  logic             data_valid;
  logic [WIDTH-1:0] dataa;
  logic [WIDTH-1:0] datab;
  logic             result_valid;
  logic [WIDTH-1:0] result;

  modport master (
    output data_valid, dataa, datab,
    input  result_valid, result
  );

  modport slave (
    input  data_valid, dataa, datab,
    output result_valid, result
  );
endinterface

// File: rtl/fp_round_ne.sv
// Round-to-nearest-even of a normalized stored mantissa from its guard and sticky bits.
// A carry means the significand reached 2.0 and the caller must renormalize.
module fp_round_ne #(
  parameter int MANT = 9
) (
  input  logic [MANT-1:0] i_mant,
  input  logic            i_guard,
  input  logic            i_sticky,
  output logic [MANT-1:0] o_mant,
  output logic            o_carry
);
  logic w_up;

  assign w_up = i_guard & (i_sticky | i_mant[0]);
  assign {o_carry, o_mant} = {1'b0, i_mant} + {{MANT{1'b0}}, w_up};
endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined floating-point multiplier: operand capture, then multiply, round and pack stages.
// Products leave exactly three edges after the operands are sampled, with a matching valid flag.
module fp_mult_pipe
  import fp_pkg::*;
#(
  parameter int EXP  = 8,
  parameter int MANT = 9
) (
  input  logic          clock,
  input  logic          clock_sreset,
  fp_mult_pipe_if.slave io_bus
);
  localparam int WIDTH = 1 + EXP + MANT;
  localparam int PW    = 2 * MANT + 2;
  localparam int EW    = EXP + 2;
  localparam logic signed [EW-1:0] BIAS      = EW'(fp_bias(EXP));
  localparam logic signed [EW-1:0] EXP_MAX   = EW'((1 << EXP) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO  = '0;
  localparam logic [WIDTH-1:0]     QNAN      = WIDTH'(fp_canon_nan(EXP, MANT));

  logic             r_vld_p0;
  logic [WIDTH-1:0] r_a_p0;
  logic [WIDTH-1:0] r_b_p0;

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_vld_p0 <= 1'b0;
      r_a_p0   <= '0;
      r_b_p0   <= '0;
    end else begin
      r_vld_p0 <= io_bus.data_valid;
      if (io_bus.data_valid) begin
        r_a_p0 <= io_bus.dataa;
        r_b_p0 <= io_bus.datab;
      end
    end
  end

  // S1: unpack, classify, exponent sum, mantissa multiply
  logic [EXP-1:0]        w_ea_p0, w_eb_p0;
  logic [MANT-1:0]       w_ma_p0, w_mb_p0;
  fp_class_t             w_cls_a_p0, w_cls_b_p0;
  logic                  w_sign_p0;
  logic signed [EW-1:0]  w_exp_p0;
  logic [PW-1:0]         w_prod_p0;

  assign w_ea_p0    = EXP'(fp_exp_field(fp_word_t'(r_a_p0), EXP, MANT));
  assign w_eb_p0    = EXP'(fp_exp_field(fp_word_t'(r_b_p0), EXP, MANT));
  assign w_ma_p0    = MANT'(fp_mant_field(fp_word_t'(r_a_p0), MANT));
  assign w_mb_p0    = MANT'(fp_mant_field(fp_word_t'(r_b_p0), MANT));
  assign w_cls_a_p0 = fp_classify(fp_word_t'(w_ea_p0), fp_word_t'(w_ma_p0), EXP);
  assign w_cls_b_p0 = fp_classify(fp_word_t'(w_eb_p0), fp_word_t'(w_mb_p0), EXP);
  assign w_sign_p0  = fp_sign(fp_word_t'(r_a_p0), EXP, MANT) ^ fp_sign(fp_word_t'(r_b_p0), EXP, MANT);
  assign w_exp_p0   = $signed({2'b00, w_ea_p0}) + $signed({2'b00, w_eb_p0}) - BIAS;
  assign w_prod_p0  = PW'({1'b1, w_ma_p0}) * PW'({1'b1, w_mb_p0});

  logic                 r_vld_p1;
  logic                 r_sign_p1;
  fp_class_t            r_cls_a_p1, r_cls_b_p1;
  logic signed [EW-1:0] r_exp_p1;
  logic [PW-1:0]        r_prod_p1;

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_vld_p1   <= 1'b0;
      r_sign_p1  <= 1'b0;
      r_cls_a_p1 <= FP_ZERO;
      r_cls_b_p1 <= FP_ZERO;
      r_exp_p1   <= '0;
      r_prod_p1  <= '0;
    end else begin
      r_vld_p1 <= r_vld_p0;
      if (r_vld_p0) begin
        r_sign_p1  <= w_sign_p0;
        r_cls_a_p1 <= w_cls_a_p0;
        r_cls_b_p1 <= w_cls_b_p0;
        r_exp_p1   <= w_exp_p0;
        r_prod_p1  <= w_prod_p0;
      end
    end
  end

  // S2: normalize to a leading one, extract guard/sticky, round
  logic                 w_msb_p1;
  logic [MANT-1:0]      w_mant_p1;
  logic                 w_guard_p1, w_sticky_p1;
  logic signed [EW-1:0] w_exp_p1;
  logic [MANT-1:0]      w_mant_rnd_p1;
  logic                 w_carry_p1;

  assign w_msb_p1    = r_prod_p1[PW-1];
  assign w_mant_p1   = w_msb_p1 ? r_prod_p1[PW-2 -: MANT] : r_prod_p1[PW-3 -: MANT];
  assign w_guard_p1  = w_msb_p1 ? r_prod_p1[MANT] : r_prod_p1[MANT-1];
  assign w_sticky_p1 = w_msb_p1 ? (|r_prod_p1[MANT-1:0]) : (|r_prod_p1[MANT-2:0]);
  assign w_exp_p1    = r_exp_p1 + $signed({{(EW-1){1'b0}}, w_msb_p1});

  fp_round_ne #(.MANT(MANT)) u_round (
    .i_mant   (w_mant_p1),
    .i_guard  (w_guard_p1),
    .i_sticky (w_sticky_p1),
    .o_mant   (w_mant_rnd_p1),
    .o_carry  (w_carry_p1)
  );

  logic                 r_vld_p2;
  logic                 r_sign_p2;
  fp_class_t            r_cls_a_p2, r_cls_b_p2;
  logic signed [EW-1:0] r_exp_p2;
  logic [MANT-1:0]      r_mant_p2;
  logic                 r_carry_p2;

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_vld_p2   <= 1'b0;
      r_sign_p2  <= 1'b0;
      r_cls_a_p2 <= FP_ZERO;
      r_cls_b_p2 <= FP_ZERO;
      r_exp_p2   <= '0;
      r_mant_p2  <= '0;
      r_carry_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_sign_p2  <= r_sign_p1;
        r_cls_a_p2 <= r_cls_a_p1;
        r_cls_b_p2 <= r_cls_b_p1;
        r_exp_p2   <= w_exp_p1;
        r_mant_p2  <= w_mant_rnd_p1;
        r_carry_p2 <= w_carry_p1;
      end
    end
  end

  // S3: renormalize, range check, special override, pack
  logic signed [EW-1:0] w_exp_p2;
  logic [MANT-1:0]      w_mant_p2;
  logic                 w_nan_p2, w_inf_p2, w_zero_p2;
  logic [WIDTH-1:0]     w_res_p2;

  assign w_exp_p2  = r_exp_p2 + $signed({{(EW-1){1'b0}}, r_carry_p2});
  assign w_mant_p2 = r_carry_p2 ? '0 : r_mant_p2;
  assign w_inf_p2  = (r_cls_a_p2 == FP_INF) || (r_cls_b_p2 == FP_INF);
  assign w_zero_p2 = (r_cls_a_p2 == FP_ZERO) || (r_cls_b_p2 == FP_ZERO);
  assign w_nan_p2  = (r_cls_a_p2 == FP_NAN) || (r_cls_b_p2 == FP_NAN) || (w_inf_p2 && w_zero_p2);

  always_comb begin
    w_res_p2 = {r_sign_p2, w_exp_p2[EXP-1:0], w_mant_p2};
    if (w_nan_p2)
      w_res_p2 = QNAN;
    else if (w_inf_p2 || (w_exp_p2 >= EXP_MAX))
      w_res_p2 = {r_sign_p2, {EXP{1'b1}}, {MANT{1'b0}}};
    else if (w_zero_p2 || (w_exp_p2 <= EXP_ZERO))
      w_res_p2 = {r_sign_p2, {(EXP + MANT){1'b0}}};
  end

  logic             r_result_valid;
  logic [WIDTH-1:0] r_result;

  always_ff @(posedge clock) begin
    if (clock_sreset) begin
      r_result_valid <= 1'b0;
      r_result       <= '0;
    end else begin
      r_result_valid <= r_vld_p2;
      if (r_vld_p2) r_result <= w_res_p2;
    end
  end

  assign io_bus.result_valid = r_result_valid;
  assign io_bus.result       = r_result;

endmodule

// File: doc/fp_mult_pipe.md
# fp_mult_pipe

Pipelined floating-point multiplier for the CNN math datapath, in the same sign/exponent/mantissa format as the rest of the floating-point library. It accepts one operand pair per cycle, returns a rounded product after a fixed 3-cycle latency, and carries a valid flag alongside the data. Its output feeds the latency-balancing delay line, which aligns products with slower parallel paths before accumulation.

## Interface
- EXP, 8, exponent width; bias = 2^(EXP-1)-1
- MANT, 9, stored mantissa width (hidden 1 implied)
- WIDTH, 1+EXP+MANT, word width: [WIDTH-1]=sign, [WIDTH-2:MANT]=exponent, [MANT-1:0]=mantissa
- clock  in  1  sole clock; all state on rising edge
- clock_sreset  in  1  synchronous, active-high reset
- data_valid  in  1  dataa/datab valid this cycle
- dataa  in  WIDTH  operand A
- datab  in  WIDTH  operand B
- result_valid  out  1  result holds a new product this cycle
- result  out  WIDTH  product

## Operation
- Classification per operand:
  - exp==0 → zero; mantissa ignored; denormals are flushed.
  - exp==all-ones, mant==0 → infinity.
  - exp==all-ones, mant!=0 → NaN.
  - Otherwise normal.
- Sign = signa XOR signb for every result except NaN.
- Specials, in priority order:
  - Any NaN input, or inf×zero → canonical NaN: sign 0, exp all-ones, mant MSB=1, rest 0.
  - Otherwise any inf → signed inf.
  - Otherwise any zero → signed zero.
- Normal path:
  - Mantissa product: (MANT+1)×(MANT+1) unsigned → 2·MANT+2 bits.
  - Exponent: ea+eb−bias, computed in EXP+2-bit signed arithmetic.
  - If product MSB is set, shift right 1 and exponent +1.
  - Round to nearest, ties to even, using guard bit plus sticky (OR of all lower bits).
  - Rounding carry-out renormalizes: mantissa → 0, exponent +1.
- Final range check on the normal path:
  - exponent ≥ 2^EXP−1 → signed inf.
  - exponent ≤ 0 → signed zero (flush-to-zero, no denormal output).
- No backpressure. Throughput is one product per cycle; every accepted input produces exactly one output.

## Timing
- Latency is exactly 3 cycles: inputs sampled at edge N appear on result/result_valid after edge N+3.
- Pipeline stages:
  - S1: unpack, classify, exponent sum, mantissa multiply.
  - S2: normalize, guard/sticky, round increment.
  - S3: renormalize, overflow/underflow, special override, pack.
- A 3-bit valid shift register accompanies the data.
- Data registers of a stage load only when that stage's valid input is 1.
- result holds its last valid value while result_valid=0.
- Reset values: result_valid=0, result=0, all internal valid bits 0, all stage data 0.
- Reset mid-operation discards in-flight products. result_valid stays 0 for the first 3 cycles after reset release unless data_valid is asserted during them, and then only at the corresponding latency.
- Back-to-back valid inputs give back-to-back valid outputs with no bubbles.
- A gap in data_valid gives the same gap in result_valid.
- data_valid asserted during the same cycle as clock_sreset is ignored.

## Structure
- Shared package fp_pkg holds:
  - fp_class_t enum {FP_ZERO, FP_NORM, FP_INF, FP_NAN}
  - bias function of EXP
  - canonical-NaN constant builder
  - field-extract helpers
- fp_pkg is reused by the adder and comparator.
- One sub-module, fp_round_ne: combinational round-to-nearest-even of a normalized mantissa with guard/sticky. It outputs the rounded mantissa and a carry, and is instantiated in S2.

## Test plan
All values use EXP=8, MANT=9; 1.0=0x0FE00.
- Basic products, 3 cycles after data_valid pulses:
  - 1.5×1.5: 0x0FF00×0x0FF00 → 0x10040 (2.25).
  - −2.0×3.0: 0x30000×0x10100 → 0x30300.
- Tie rounding: 0x0FE01×0x0FF00 → 0x0FF02, ties round up to even.
- Below-half rounding: 0x0FE01×0x0FE01 → 0x0FE02, rounded down.
- Specials:
  - Overflow: 0x1FDFF squared → 0x1FE00 (+inf).
  - Underflow: 0x00200×0x00200 → 0x00000.
  - inf×zero: 0x1FE00×0x00000 → 0x1FF00 (canonical NaN).
  - Sign of zero: 0x20000×0x0FE00 → 0x20000 (−0).
- Streaming: 16 consecutive valid random normal pairs, then 2-cycle gap, then 4 more.
  - result_valid pattern equals data_valid delayed by 3.
  - Results match the reference model bit-exactly.
  - result is stable during the gap.
- Reset mid-stream: assert clock_sreset 1 cycle while 3 products are in flight.
  - result_valid=0 and result=0 the next cycle.
  - No stale product ever appears.
  - The first post-reset input emerges 3 cycles later.
